// File: rtl/rvvi_pkg.sv
// Shared types and sizes for the RVVI trace producer.
// One slot holds everything needed to emit one retirement record.
package rvvi_pkg;

  localparam int XLEN     = 32;
  localparam int ILEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int NUM_CSRS = 4096;

  localparam logic [1:0] IXL = (XLEN == 64) ? 2'd2 : 2'd1;

  typedef struct packed {
    logic [ILEN-1:0] insn;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic            trap;
    logic            halt;
    logic [1:0]      mode;
    logic [4:0]      rd;
    logic            rd_we;
    logic            pending;
    logic [XLEN-1:0] data;
    logic            csr_we;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_data;
  } rvvi_slot_t;

endpackage

// File: rtl/rvvi_trace_gen_if.sv
// Retire-event and deferred write-back bundle between core and tracer.
// master = core retire stage, slave = trace producer.
interface rvvi_trace_gen_if #(
  parameter int DEPTH = 4
);
  import rvvi_pkg::*;

  localparam int TW = $clog2(DEPTH);

  logic            ret_valid;
  logic            ret_ready;
  logic [ILEN-1:0] ret_insn;
  logic [XLEN-1:0] ret_pc;
  logic [XLEN-1:0] ret_npc;
  logic            ret_trap;
  logic            ret_halt;
  logic [1:0]      ret_mode;
  logic [4:0]      ret_rd;
  logic            ret_rd_we;
  logic            ret_rd_pend;
  logic [XLEN-1:0] ret_rd_data;
  logic            ret_csr_we;
  logic [11:0]     ret_csr_addr;
  logic [XLEN-1:0] ret_csr_data;
  logic [TW-1:0]   ret_tag;
  logic            wb_valid;
  logic [TW-1:0]   wb_tag;
  logic [XLEN-1:0] wb_data;

  modport master (
    output ret_valid, ret_insn, ret_pc, ret_npc,
    output ret_trap, ret_halt, ret_mode,
    output ret_rd, ret_rd_we, ret_rd_pend,
    output ret_rd_data, ret_csr_we,
    output ret_csr_addr, ret_csr_data,
    output wb_valid, wb_tag, wb_data,
    input  ret_ready, ret_tag
  );

  modport slave (
    input  ret_valid, ret_insn, ret_pc, ret_npc,
    input  ret_trap, ret_halt, ret_mode,
    input  ret_rd, ret_rd_we, ret_rd_pend,
    input  ret_rd_data, ret_csr_we,
    input  ret_csr_addr, ret_csr_data,
    input  wb_valid, wb_tag, wb_data,
    output ret_ready, ret_tag
  );

endinterface

// File: rtl/rvvi_trace_slots.sv
// In-order retire ring: allocation, deferred write-back, head selection.
// An empty ring forwards a ready event straight to the emit path.
module rvvi_trace_slots
  import rvvi_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int TW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  rvvi_trace_gen_if.slave rif,
  output logic       emit_o,
  output rvvi_slot_t rec_o,
  output logic       err_o
);

  rvvi_slot_t    slot_q [DEPTH];
  logic [TW-1:0] head_q;
  logic [TW-1:0] tail_q;
  logic [TW:0]   count_q;
  logic [TW:0]   count_d;
  logic          err_q;

  rvvi_slot_t    new_s;
  logic [TW-1:0] wb_off;
  logic          accept;
  logic          wb_occ;
  logic          wb_hit;
  logic          head_byp;
  logic          emit_head;
  logic          emit_new;

  assign rif.ret_ready = count_q < (TW+1)'(DEPTH);
  assign rif.ret_tag   = tail_q;
  assign accept = rif.ret_valid && rif.ret_ready;

  always_comb begin
    new_s          = '0;
    new_s.insn     = rif.ret_insn;
    new_s.pc       = rif.ret_pc;
    new_s.npc      = rif.ret_npc;
    new_s.trap     = rif.ret_trap;
    new_s.halt     = rif.ret_halt;
    new_s.mode     = rif.ret_mode;
    new_s.rd       = rif.ret_rd;
    new_s.rd_we    = rif.ret_rd_we;
    new_s.pending  = rif.ret_rd_we && rif.ret_rd_pend
                     && !rif.ret_trap;
    new_s.data     = rif.ret_rd_data;
    new_s.csr_we   = rif.ret_csr_we;
    new_s.csr_addr = rif.ret_csr_addr;
    new_s.csr_data = rif.ret_csr_data;
  end

  // Slot is live when its distance from head is below count.
  assign wb_off   = rif.wb_tag - head_q;
  assign wb_occ   = {1'b0, wb_off} < count_q;
  assign wb_hit   = rif.wb_valid && wb_occ
                    && slot_q[rif.wb_tag].pending;
  assign head_byp = wb_hit && (rif.wb_tag == head_q);

  assign emit_head = (count_q != '0)
                     && (!slot_q[head_q].pending || head_byp);
  assign emit_new  = (count_q == '0) && accept
                     && !new_s.pending;
  assign emit_o    = emit_head || emit_new;

  always_comb begin
    rec_o = slot_q[head_q];
    if (head_byp) rec_o.data = rif.wb_data;
    if (emit_new) rec_o = new_s;
  end

  assign count_d = count_q + (TW+1)'(accept)
                   - (TW+1)'(emit_o);

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
    end else begin
      if (accept) begin
        slot_q[tail_q] <= new_s;
        tail_q         <= tail_q + TW'(1);
      end
      if (wb_hit) begin
        slot_q[rif.wb_tag].data    <= rif.wb_data;
        slot_q[rif.wb_tag].pending <= 1'b0;
      end
      if (emit_o) head_q <= head_q + TW'(1);
      count_q <= count_d;
      if (rif.wb_valid && !wb_hit) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/rvvi_trace_gen.sv
// RVVI producer top: order counter, shadow X file, registered record.
// Slot ordering and write-back matching live in rvvi_trace_slots.
module rvvi_trace_gen
  import rvvi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  rvvi_trace_gen_if.slave     rif,
  output logic                valid,
  output logic [63:0]         order,
  output logic [ILEN-1:0]     insn,
  output logic [XLEN-1:0]     pc_rdata,
  output logic [XLEN-1:0]     pc_wdata,
  output logic                trap,
  output logic                halt,
  output logic [1:0]          mode,
  output logic [1:0]          ixl,
  output logic [XLEN-1:0]     x_wdata [NUM_REGS],
  output logic [NUM_REGS-1:0] x_wb,
  output logic [NUM_CSRS-1:0] csr_wb,
  output logic [XLEN-1:0]     csr_wdata,
  output logic                err
);

  logic          emit;
  rvvi_slot_t    rec;
  logic          rd_wr;
  logic          unused_pend;

  logic                valid_q;
  logic [63:0]         order_q;
  logic [ILEN-1:0]     insn_q;
  logic [XLEN-1:0]     pc_rdata_q;
  logic [XLEN-1:0]     pc_wdata_q;
  logic                trap_q;
  logic                halt_q;
  logic [1:0]          mode_q;
  logic [XLEN-1:0]     x_q [NUM_REGS];
  logic [NUM_REGS-1:0] x_wb_q;
  logic [NUM_REGS-1:0] x_wb_d;
  logic [NUM_CSRS-1:0] csr_wb_q;
  logic [NUM_CSRS-1:0] csr_wb_d;
  logic [XLEN-1:0]     csr_wdata_q;

  rvvi_trace_slots #(.DEPTH(DEPTH)) u_slots (
    .clk    (clk),
    .rst    (rst),
    .rif    (rif),
    .emit_o (emit),
    .rec_o  (rec),
    .err_o  (err)
  );

  assign unused_pend = rec.pending;

  // x0 is never written, so its shadow entry stays at reset zero.
  assign rd_wr    = rec.rd_we && !rec.trap && (rec.rd != 5'd0);
  assign x_wb_d   = rd_wr ? (NUM_REGS'(1) << rec.rd) : '0;
  assign csr_wb_d = (rec.csr_we && !rec.trap)
                    ? (NUM_CSRS'(1) << rec.csr_addr) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      order_q     <= '0;
      insn_q      <= '0;
      pc_rdata_q  <= '0;
      pc_wdata_q  <= '0;
      trap_q      <= 1'b0;
      halt_q      <= 1'b0;
      mode_q      <= '0;
      x_wb_q      <= '0;
      csr_wb_q    <= '0;
      csr_wdata_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) x_q[i] <= '0;
    end else begin
      valid_q  <= emit;
      x_wb_q   <= '0;
      csr_wb_q <= '0;
      if (emit) begin
        order_q     <= order_q + 64'd1;
        insn_q      <= rec.insn;
        pc_rdata_q  <= rec.pc;
        pc_wdata_q  <= rec.npc;
        trap_q      <= rec.trap;
        halt_q      <= rec.halt;
        mode_q      <= rec.mode;
        x_wb_q      <= x_wb_d;
        csr_wb_q    <= csr_wb_d;
        csr_wdata_q <= rec.csr_data;
        if (rd_wr) x_q[rec.rd] <= rec.data;
      end
    end
  end

  assign valid     = valid_q;
  assign order     = order_q;
  assign insn      = insn_q;
  assign pc_rdata  = pc_rdata_q;
  assign pc_wdata  = pc_wdata_q;
  assign trap      = trap_q;
  assign halt      = halt_q;
  assign mode      = mode_q;
  assign ixl       = IXL;
  assign x_wdata   = x_q;
  assign x_wb      = x_wb_q;
  assign csr_wb    = csr_wb_q;
  assign csr_wdata = csr_wdata_q;

endmodule

// File: tb/tb_rvvi_trace_gen.sv
// Bench for rvvi_trace_gen: directed scenarios then random traffic,
// each cycle compared against an in-order retire queue model.
module tb_rvvi_trace_gen;
  import rvvi_pkg::*;

  localparam int DEPTH = 4;
  localparam int TW = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rvvi_trace_gen_if #(.DEPTH(DEPTH)) rif ();

  logic                valid;
  logic [63:0]         order;
  logic [ILEN-1:0]     insn;
  logic [XLEN-1:0]     pc_rdata;
  logic [XLEN-1:0]     pc_wdata;
  logic                trap;
  logic                halt;
  logic [1:0]          mode;
  logic [1:0]          ixl;
  logic [XLEN-1:0]     x_wdata [NUM_REGS];
  logic [NUM_REGS-1:0] x_wb;
  logic [NUM_CSRS-1:0] csr_wb;
  logic [XLEN-1:0]     csr_wdata;
  logic                err;

  rvvi_trace_gen #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rif(rif),
    .valid(valid), .order(order), .insn(insn),
    .pc_rdata(pc_rdata), .pc_wdata(pc_wdata),
    .trap(trap), .halt(halt), .mode(mode), .ixl(ixl),
    .x_wdata(x_wdata), .x_wb(x_wb),
    .csr_wb(csr_wb), .csr_wdata(csr_wdata), .err(err)
  );

  typedef struct {
    logic [31:0] insn;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        trap;
    logic        halt;
    logic [1:0]  mode;
    logic [4:0]  rd;
    logic        we;
    logic        pend;
    logic [31:0] data;
    logic        cwe;
    logic [11:0] caddr;
    logic [31:0] cdata;
    int          tag;
  } ev_t;

  ev_t             mq [$];
  logic [31:0]     sh [32];
  longint unsigned m_order;
  logic            m_err;
  int              m_tail;
  int              checks = 0;
  int              errors = 0;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic idle();
    rif.ret_valid = 1'b0;
    rif.wb_valid  = 1'b0;
  endtask

  task automatic offer(logic [31:0] i, logic [31:0] pc,
                       logic [4:0] rd, logic we, logic pend,
                       logic [31:0] d, logic trp, logic cwe,
                       logic [11:0] ca, logic [31:0] cd);
    rif.ret_valid    = 1'b1;
    rif.ret_insn     = i;
    rif.ret_pc       = pc;
    rif.ret_npc      = pc + 32'd4;
    rif.ret_trap     = trp;
    rif.ret_halt     = 1'b0;
    rif.ret_mode     = 2'd3;
    rif.ret_rd       = rd;
    rif.ret_rd_we    = we;
    rif.ret_rd_pend  = pend;
    rif.ret_rd_data  = d;
    rif.ret_csr_we   = cwe;
    rif.ret_csr_addr = ca;
    rif.ret_csr_data = cd;
  endtask

  task automatic wb(int tag, logic [31:0] d);
    rif.wb_valid = 1'b1;
    rif.wb_tag   = TW'(tag);
    rif.wb_data  = d;
  endtask

  // One clock: advance the model from the inputs, then compare.
  task automatic cyc();
    ev_t            e;
    ev_t            x;
    bit             rdy;
    bit             hit;
    bit             ev;
    logic [31:0]    exw;
    logic [4095:0]  ecw;
    rdy = mq.size() < DEPTH;
    chk("ret_ready", rif.ret_ready, rdy);
    if (rif.wb_valid) begin
      hit = 0;
      foreach (mq[i])
        if (mq[i].tag == int'(rif.wb_tag) && mq[i].pend) begin
          mq[i].data = rif.wb_data;
          mq[i].pend = 1'b0;
          hit = 1;
        end
      if (!hit) m_err = 1'b1;
    end
    if (rif.ret_valid && rdy) begin
      chk("ret_tag", rif.ret_tag, m_tail);
      e.insn  = rif.ret_insn;
      e.pc    = rif.ret_pc;
      e.npc   = rif.ret_npc;
      e.trap  = rif.ret_trap;
      e.halt  = rif.ret_halt;
      e.mode  = rif.ret_mode;
      e.rd    = rif.ret_rd;
      e.we    = rif.ret_rd_we;
      e.pend  = rif.ret_rd_we && rif.ret_rd_pend && !rif.ret_trap;
      e.data  = rif.ret_rd_data;
      e.cwe   = rif.ret_csr_we;
      e.caddr = rif.ret_csr_addr;
      e.cdata = rif.ret_csr_data;
      e.tag   = m_tail;
      m_tail  = (m_tail + 1) % DEPTH;
      mq.push_back(e);
    end
    ev  = 0;
    exw = '0;
    ecw = '0;
    if (mq.size() > 0 && !mq[0].pend) begin
      x  = mq.pop_front();
      ev = 1;
      m_order++;
      if (x.we && !x.trap && x.rd != 0) begin
        sh[x.rd] = x.data;
        exw[x.rd] = 1'b1;
      end
      if (x.cwe && !x.trap) ecw[x.caddr] = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("valid", valid, ev);
    if (ev) begin
      chk("order", order, m_order);
      chk("insn", insn, x.insn);
      chk("pc_rdata", pc_rdata, x.pc);
      chk("pc_wdata", pc_wdata, x.npc);
      chk("trap", trap, x.trap);
      chk("halt", halt, x.halt);
      chk("mode", mode, x.mode);
      chk("x_wb", x_wb, exw);
      chk("csr_wb_eq", 64'(csr_wb === ecw), 64'd1);
      chk("csr_wdata", csr_wdata, x.cdata);
    end
    for (int r = 0; r < 32; r++)
      chk($sformatf("x_wdata[%0d]", r), x_wdata[r], sh[r]);
    chk("err", err, m_err);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    m_order = 0;
    m_err   = 1'b0;
    m_tail  = 0;
    foreach (sh[i]) sh[i] = '0;
    chk("rst_valid", valid, 0);
    chk("rst_order", order, 0);
    chk("rst_x_wb", x_wb, 0);
    chk("rst_csr_wb_zero", 64'(csr_wb == '0), 64'd1);
    chk("rst_ready", rif.ret_ready, 1);
    chk("rst_err", err, 0);
  endtask

  initial begin
    rif.ret_insn     = '0;
    rif.ret_pc       = '0;
    rif.ret_npc      = '0;
    rif.ret_trap     = 1'b0;
    rif.ret_halt     = 1'b0;
    rif.ret_mode     = '0;
    rif.ret_rd       = '0;
    rif.ret_rd_we    = 1'b0;
    rif.ret_rd_pend  = 1'b0;
    rif.ret_rd_data  = '0;
    rif.ret_csr_we   = 1'b0;
    rif.ret_csr_addr = '0;
    rif.ret_csr_data = '0;
    rif.wb_tag       = '0;
    rif.wb_data      = '0;
    idle();

    do_reset();
    chk("rst_pc", pc_rdata, 0);
    chk("ixl", ixl, 1);

    // single addi x5
    offer(32'h0000_0293, 32'h100, 5'd5, 1, 0, 32'h11,
          0, 0, 12'h0, 0);
    cyc();
    idle();
    chk("addi_order", order, 1);
    chk("addi_x_wb", x_wb, 32'h20);
    chk("addi_x5", x_wdata[5], 32'h11);
    cyc();

    // deferred load then two ALU ops
    do_reset();
    offer(32'h0000_2183, 32'h200, 5'd3, 1, 1, 0, 0, 0, 0, 0);
    cyc();
    offer(32'h0000_0313, 32'h204, 5'd6, 1, 0, 32'h22,
          0, 0, 0, 0);
    cyc();
    offer(32'h0000_0393, 32'h208, 5'd7, 1, 0, 32'h33,
          0, 0, 0, 0);
    cyc();
    idle();
    cyc();
    cyc();
    wb(0, 32'hAB);
    cyc();
    idle();
    chk("load_order", order, 1);
    chk("load_pc", pc_rdata, 32'h200);
    chk("load_x3", x_wdata[3], 32'hAB);
    cyc();
    chk("alu1_order", order, 2);
    cyc();
    chk("alu2_order", order, 3);
    cyc();

    // fill ring with pending loads
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      offer(32'h0000_0003, 32'h300 + 32'(4 * k),
            5'(8 + k), 1, 1, 0, 0, 0, 0, 0);
      cyc();
    end
    offer(32'h0000_0013, 32'h310, 5'd12, 1, 0, 32'h5,
          0, 0, 0, 0);
    chk("full_ready", rif.ret_ready, 0);
    cyc();
    idle();
    wb(0, 32'h100);
    cyc();
    idle();
    chk("ready_after_emit", rif.ret_ready, 1);
    for (int k = 1; k < DEPTH; k++) begin
      wb(k, 32'h100 + 32'(k));
      cyc();
    end
    idle();
    cyc();

    // trapped instruction with rd and csr writes
    offer(32'h0000_0073, 32'h400, 5'd9, 1, 0, 32'hDEAD,
          1, 1, 12'h300, 32'h5);
    cyc();
    idle();
    chk("trap_flag", trap, 1);
    chk("trap_x_wb", x_wb, 0);
    chk("trap_csr_zero", 64'(csr_wb == '0), 64'd1);
    offer(32'h3400_1073, 32'h404, 5'd0, 0, 0, 0,
          0, 1, 12'h340, 32'hCAFE);
    cyc();
    idle();
    chk("csr_bit", csr_wb[12'h340], 1);
    chk("csr_data", csr_wdata, 32'hCAFE);

    // x0 write and stray write-back
    offer(32'h0550_0013, 32'h500, 5'd0, 1, 0, 32'h55,
          0, 0, 0, 0);
    cyc();
    idle();
    chk("x0_x_wb", x_wb, 0);
    chk("x0_val", x_wdata[0], 0);
    wb(2, 32'h77);
    cyc();
    idle();
    chk("stray_err", err, 1);
    chk("stray_valid", valid, 0);
    cyc();
    chk("err_sticky", err, 1);

    // reset with occupied slots
    do_reset();
    for (int k = 0; k < 3; k++) begin
      offer(32'h0000_0003, 32'h600 + 32'(4 * k),
            5'(1 + k), 1, 1, 0, 0, 0, 0, 0);
      cyc();
    end
    idle();
    do_reset();
    cyc();
    cyc();
    offer(32'h0010_0093, 32'h700, 5'd1, 1, 0, 32'h1,
          0, 0, 0, 0);
    cyc();
    idle();
    chk("post_rst_order", order, 1);

    // random traffic
    do_reset();
    for (int k = 0; k < 400; k++) begin
      int pt [$];
      idle();
      if ($urandom_range(0, 2) != 0)
        offer($urandom, $urandom & 32'hFFFF_FFFC,
              5'($urandom_range(0, 31)),
              1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 2) == 0),
              $urandom,
              1'($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 3) == 0),
              12'($urandom_range(0, 4095)),
              $urandom);
      rif.ret_halt = 1'($urandom_range(0, 15) == 0);
      rif.ret_mode = 2'($urandom_range(0, 3));
      foreach (mq[i]) if (mq[i].pend) pt.push_back(mq[i].tag);
      if (pt.size() > 0 && $urandom_range(0, 2) == 0)
        wb(pt[$urandom_range(0, pt.size() - 1)], $urandom);
      cyc();
    end
    for (int k = 0; k < 3 * DEPTH; k++) begin
      int pt [$];
      idle();
      foreach (mq[i]) if (mq[i].pend) pt.push_back(mq[i].tag);
      if (pt.size() > 0) wb(pt[0], $urandom);
      cyc();
    end
    idle();
    chk("drained_ready", rif.ret_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rvvi_trace_gen.md
# rvvi_trace_gen

Synthesizable RVVI producer for one hart, one issue lane, sitting between a core's retire stage and the RVVI_VLG trace interface. Accepts retire events, holds them in order while deferred load/long-latency write-backs complete, and emits exactly one RVVI record per retired instruction. Drives a monotonic `order` count and a shadow X register file so `x_wdata` always shows the architectural state after each retirement.

## Interface
- `XLEN`, 32, data/PC width
- `ILEN`, 32, instruction width
- `DEPTH`, 4, retire slots (power of two, ≥2); `TW = $clog2(DEPTH)`
- `clk  in  1  clock, rising edge`
- `rst  in  1  synchronous, active-high reset`
- `ret_valid  in  1  retire event offered`
- `ret_ready  out  1  slot free; event accepted when valid&&ready`
- `ret_insn  in  ILEN  instruction bits`
- `ret_pc, ret_npc  in  XLEN  PC of insn / next PC`
- `ret_trap, ret_halt  in  1  trapped / halted`
- `ret_mode  in  2  privilege mode`
- `ret_rd  in  5  destination register`
- `ret_rd_we  in  1  instruction writes rd`
- `ret_rd_pend  in  1  rd value arrives later via wb port`
- `ret_rd_data  in  XLEN  rd value when not pending`
- `ret_csr_we  in  1; ret_csr_addr  in  12; ret_csr_data  in  XLEN  single CSR write`
- `ret_tag  out  TW  slot index assigned to the accepted event`
- `wb_valid  in  1; wb_tag  in  TW; wb_data  in  XLEN  deferred rd value`
- `valid  out  1  RVVI record valid (one-cycle pulse)`
- `order  out  64  record sequence number`
- `insn, pc_rdata, pc_wdata, trap, halt, mode, ixl  out  per RVVI`
- `x_wdata  out  32×XLEN  shadow X file; x_wb  out  32  one-hot rd written`
- `csr_wb  out  4096  one-hot CSR written; csr_wdata  out  XLEN  value of that CSR`
- `err  out  1  sticky protocol error`

## Operation
- Slots allocated in ring order (tail pointer); emitted in ring order (head pointer). Count 0..DEPTH.
- `ret_ready = (count < DEPTH)`; combinational from state only, never from `ret_valid`.
- On accept: slot captures all fields; `pending = ret_rd_we && ret_rd_pend && !ret_trap`; `ret_tag = tail`.
- On `wb_valid`: if slot `wb_tag` is occupied and pending, store `wb_data`, clear pending. Otherwise ignore, set `err`.
- Head emits when occupied and (not pending, or `wb_valid` targets head this cycle — bypass). At most one emit per cycle; no back-pressure on RVVI side.
- On emit: `order` ← `order+1`; if `rd_we && !trap && rd!=0`, shadow[rd] ← data and `x_wb` = 1<<rd, else `x_wb`=0. x0 reads 0 always.
- `csr_wb` = 1<<addr if `csr_we && !trap`, else 0; `csr_wdata` = captured data.
- `ixl` constant: 1 for XLEN 32, 2 for XLEN 64.
- Accept and emit in same cycle: count unchanged; accepted when full is impossible (ready=0 even if emit).

## Timing
- All RVVI outputs registered. Non-pending event accepted at cycle N into empty buffer → `valid` at N+1.
- Pending event: wb at cycle M → `valid` at M+1 (if head).
- Reset values: `valid`=0, `order`=0, `x_wdata`=0, `x_wb`=0, `csr_wb`=0, all record fields 0, `ret_ready`=1, `err`=0, head=tail=count=0. First emitted `order`=1.
- Reset mid-operation discards all slots; no record emitted for them; `order` restarts.
- Wrap-around: pointers wrap mod DEPTH; `order` wraps at 2^64 (not tested).

## Structure
- `rvvi_pkg`: `rvvi_slot_t` struct (insn, pc, npc, trap, halt, mode, rd, rd_we, pending, data, csr fields), `NUM_REGS=32`, `NUM_CSRS=4096`.
- Sub-module `rvvi_trace_slots`: slot storage, pointers, count, wb update, head-ready/bypass. Top holds shadow file, order counter, output registers.

## Test plan
- Single `addi x5` retire, rd_data=0x11 → `valid` next cycle, order=1, x_wb=0x20, x_wdata[5]=0x11.
- Load rd=3 pending (tag 0), then two ALU retires, wb tag0=0xAB three cycles later → nothing emitted until wb; then orders 1,2,3 on consecutive cycles, load first.
- Fill DEPTH=4 pending slots → `ret_ready`=0; one wb to head → ready=1 the cycle after the emit.
- Trapped insn with rd_we=1, csr_we=1 → trap=1, x_wb=0, csr_wb=0, shadow unchanged.
- Write to x0 → x_wb=0, x_wdata[0]=0; wb to empty slot → `err`=1 sticky, no record.
- `rst` asserted with 3 slots occupied → valid stays 0; next retire emits order=1.
